range_frame_sender: RTL and testbench

//  Transmit side of the go/finish framed-data interface that feeds the range finder.

---
 rtl/range_pkg.sv | 5 +
 rtl/range_fifo.sv | 49 ++++
 rtl/range_frame_sender.sv | 107 ++++++++++
 tb/tb_range_frame_sender.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Shared types and constants for the range finder frame sender.
package range_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, SEND} sender_state_t;
    localparam int MIN_FRAME_LEN = 2;
endpackage

// File: rtl/range_fifo.sv
// Synchronous FIFO with occupancy count and first-word-fall-through head.
module range_fifo
    import range_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LEN_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full  = (count == LEN_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LEN_W'(1);
                2'b01:   count <= count - LEN_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/range_frame_sender.sv
// Buffers upstream words and emits go/finish framed bursts of N words on request.
module range_frame_sender
    import range_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             send,
    input  logic [LEN_W-1:0] send_len,
    input  logic             abort,
    output logic             busy,
    output logic             req_err,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish
);
    sender_state_t    state;
    logic [LEN_W-1:0] frame_len;
    logic [LEN_W-1:0] remaining;
    logic [WIDTH-1:0] head;
    logic [LEN_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             len_ok;

    assign wr_ready = ~full;
    assign push     = wr_valid & wr_ready;
    assign busy     = (state != IDLE);
    assign len_ok   = (send_len >= LEN_W'(MIN_FRAME_LEN)) && (send_len <= LEN_W'(DEPTH));

    // Frame start waits for the whole frame to be buffered, so SEND never starves.
    assign pop = ((state == WAIT) && !abort && (count >= frame_len)) ||
                 ((state == SEND) && !empty);

    range_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_data (wr_data),
        .push    (push),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            frame_len <= '0;
            remaining <= '0;
            data_out  <= '0;
            go        <= 1'b0;
            finish    <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            data_out <= '0;
            go       <= 1'b0;
            finish   <= 1'b0;
            req_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        if (len_ok) begin
                            frame_len <= send_len;
                            state     <= WAIT;
                        end else begin
                            req_err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    req_err <= send;
                    if (abort) begin
                        state <= IDLE;
                    end else if (pop) begin
                        data_out  <= head;
                        go        <= 1'b1;
                        remaining <= frame_len - LEN_W'(1);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    req_err  <= send;
                    data_out <= head;
                    // Abort still sends one more word so the frame closes with finish.
                    if (abort || remaining <= LEN_W'(1)) begin
                        finish    <= 1'b1;
                        remaining <= '0;
                        state     <= IDLE;
                    end else begin
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_range_frame_sender.sv
// Directed bench: model FIFO and expected-frame scoreboard checked by a negedge monitor.
module tb_range_frame_sender;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int LEN_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             go;
        logic             fin;
    } word_t;

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             send;
    logic [LEN_W-1:0] send_len;
    logic             abort;
    logic             busy;
    logic             req_err;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] mdl [$];
    word_t            exp_q [$];
    logic             in_frame = 1'b0;

    range_frame_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .send     (send),
        .send_len (send_len),
        .abort    (abort),
        .busy     (busy),
        .req_err  (req_err),
        .data_out (data_out),
        .go       (go),
        .finish   (finish)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: every word inside a frame must match the scoreboard head.
    always @(negedge clock) begin
        if (!reset_n) begin
            in_frame = 1'b0;
        end else if (go || in_frame) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {data_out, go, finish}, 32'hFFFF_FFFF);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("frame_word", {data_out, go, finish}, {w.data, w.go, w.fin});
            end
            in_frame = finish ? 1'b0 : 1'b1;
        end
    end

    task automatic push_word(input logic [WIDTH-1:0] d, input bit to_mdl);
        int guard = 0;
        while (!wr_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!wr_ready) check("push_timeout", 32'd0, 32'd1);
        wr_data  = d;
        wr_valid = 1'b1;
        @(posedge clock); #1;
        wr_valid = 1'b0;
        if (to_mdl) mdl.push_back(d);
    endtask

    task automatic do_send(input int n);
        send_len = LEN_W'(n);
        send     = 1'b1;
        @(posedge clock); #1;
        send     = 1'b0;
    endtask

    task automatic expect_from_model(input int n);
        for (int i = 0; i < n; i++) begin
            word_t w;
            w.data = mdl.pop_front();
            w.go   = (i == 0);
            w.fin  = (i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_idle_drained(input string tag);
        int guard = 0;
        while (busy && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        @(negedge clock); #1;
        check({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        send     = 1'b0;
        send_len = '0;
        abort    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_outs", {data_out, go, finish, req_err}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Basic frame and latency.
        push_word(16'd10, 1); push_word(16'd3, 1); push_word(16'd7, 1); push_word(16'd25, 1);
        do_send(4);
        expect_from_model(4);
        check("wait_no_go", {31'd0, go}, 32'd0);
        @(posedge clock); #1;
        check("go_word0", {data_out, go, finish}, {16'd10, 1'b1, 1'b0});
        repeat (3) @(posedge clock);
        #1;
        check("finish_word3", {data_out, go, finish}, {16'd25, 1'b0, 1'b1});
        check("busy_after", {31'd0, busy}, 32'd0);
        wait_idle_drained("t1");

        // Out-of-range lengths are rejected.
        push_word(16'h55, 1);
        do_send(1);
        check("err_len1", {31'd0, req_err}, 32'd1);
        check("err_len1_busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        check("err_pulse_end", {31'd0, req_err}, 32'd0);
        do_send(DEPTH + 1);
        check("err_lenmax", {31'd0, req_err}, 32'd1);
        @(posedge clock); #1;
        check("err_count", 32'(dut.u_fifo.count), mdl.size());
        do_send(2);
        push_word(16'h66, 1);
        expect_from_model(2);
        wait_idle_drained("t2");

        // Frame waits until fully buffered.
        do_send(3);
        exp_q.push_back('{16'd5, 1'b1, 1'b0});
        exp_q.push_back('{16'd9, 1'b0, 1'b0});
        exp_q.push_back('{16'd2, 1'b0, 1'b1});
        push_word(16'd5, 0); push_word(16'd9, 0); push_word(16'd2, 0);
        check("starve_no_go", {31'd0, go}, 32'd0);
        @(posedge clock); #1;
        check("starve_go", {data_out, go}, {16'd5, 1'b1});
        wait_idle_drained("t3");

        // Abort mid-frame, with a rejected send in the same cycle.
        for (int i = 0; i < 6; i++) push_word(WIDTH'(11 + i), 1);
        do_send(6);
        expect_from_model(4);
        repeat (3) @(posedge clock);
        #1;
        abort = 1'b1; send = 1'b1; send_len = LEN_W'(2);
        @(posedge clock); #1;
        abort = 1'b0; send = 1'b0;
        check("abort_finish", {data_out, finish}, {16'd14, 1'b1});
        check("abort_req_err", {31'd0, req_err}, 32'd1);
        wait_idle_drained("t4");
        check("abort_count", 32'(dut.u_fifo.count), 32'd2);
        do_send(2);
        expect_from_model(2);
        wait_idle_drained("t4b");

        // Full FIFO, send while pushing continuously.
        for (int i = 0; i < DEPTH; i++) push_word(WIDTH'(40 + i), 1);
        check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        expect_from_model(DEPTH);
        send_len = LEN_W'(DEPTH);
        send     = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic acc;
            wr_data = WIDTH'(100 + i);
            acc = wr_ready;
            @(posedge clock); #1;
            send = 1'b0;
            if (acc) mdl.push_back(WIDTH'(100 + i));
            checks++;
            assert (dut.u_fifo.count >= LEN_W'(DEPTH - 1) && dut.u_fifo.count <= LEN_W'(DEPTH)) else begin
                errors++;
                $error("FAIL stream_count: observed %0d expected %0d..%0d", dut.u_fifo.count, DEPTH - 1, DEPTH);
            end
        end
        wr_valid = 1'b0;
        wait_idle_drained("t5");
        check("stream_final_count", 32'(dut.u_fifo.count), mdl.size());

        // Reset mid-frame.
        do_send(DEPTH);
        expect_from_model(DEPTH);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_outs", {data_out, go, finish}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_count", 32'(dut.u_fifo.count), 32'd0);
        check("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
        exp_q.delete();
        mdl.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        push_word(16'hA1, 1); push_word(16'hB2, 1);
        do_send(2);
        expect_from_model(2);
        wait_idle_drained("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
